// File: rtl/fb_write_scheduler.sv
// fb_write_scheduler: feeds pixels from NUM_CORES cores, strictly interleaved, into the framebuffer four-phase write port.
// Optional ack watchdog enabled by defining FB_WRITE_SCHEDULER_ACK_TIMEOUT_EN.
module fb_write_scheduler #(
   parameter int NUM_CORES        = 2,
   parameter int PIXELS_PER_FRAME = 153600,
   parameter int PTR_RESET_CYCLES = 4,
   parameter int ACK_TIMEOUT      = 255,
   localparam int CW = (PIXELS_PER_FRAME > 1) ? $clog2(PIXELS_PER_FRAME) : 1
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   frame_start_in,
   input  logic [NUM_CORES-1:0]   core_valid_in,
   input  logic [4*NUM_CORES-1:0] core_data_in,
   output logic [NUM_CORES-1:0]   core_ready_out,
   output logic [3:0]             write_data_out,
   output logic                   write_strobe_out,
   output logic                   reset_write_ptr_out,
   input  logic                   wrote_data_in,
   output logic                   frame_done_out,
   output logic                   busy_out,
`ifdef FB_WRITE_SCHEDULER_ACK_TIMEOUT_EN
   output logic                   ack_timeout_out,
`endif
   output logic [CW-1:0]          pixel_index_out
);
   localparam int TW = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
   localparam int PW = (PTR_RESET_CYCLES > 1) ? $clog2(PTR_RESET_CYCLES) : 1;
   localparam logic [CW-1:0] LAST_PIX  = CW'(PIXELS_PER_FRAME - 1);
   localparam logic [PW-1:0] LAST_PTR  = PW'(PTR_RESET_CYCLES - 1);
   localparam logic [TW-1:0] LAST_CORE = TW'(NUM_CORES - 1);

   typedef enum logic [2:0] {IDLE, PTR_RST, WAIT_PIX, WR_REQ, WR_REL} state_t;

   state_t          state, nxt;
   logic [TW-1:0]   turn, nxt_turn;
   logic [CW-1:0]   count, nxt_count;
   logic [PW-1:0]   ptr_cnt;
   logic            pend, xfer, done, restart, restart_req;
   logic [3:0]      pix;

   assign restart_req     = pend | frame_start_in;
   assign pix             = core_data_in[4*turn +: 4];
   assign pixel_index_out = count;

`ifdef FB_WRITE_SCHEDULER_ACK_TIMEOUT_EN
   localparam int AW = $clog2(ACK_TIMEOUT + 1);
   localparam logic [AW-1:0] ACK_LIM = AW'(ACK_TIMEOUT - 1);
   logic [AW-1:0] ack_cnt;
   logic          tmo;
`endif

   always_comb begin
      nxt       = state;
      nxt_turn  = turn;
      nxt_count = count;
      xfer      = 1'b0;
      done      = 1'b0;
      restart   = 1'b0;
      case (state)
         IDLE:     restart = frame_start_in;
         PTR_RST: begin
            nxt_turn  = '0;
            nxt_count = '0;
            if (ptr_cnt == LAST_PTR) begin
               restart = restart_req;
               nxt     = restart_req ? PTR_RST : WAIT_PIX;
            end
         end
         // a transfer already granted wins over a restart request arriving in the same cycle
         WAIT_PIX: begin
            xfer    = core_valid_in[turn];
            restart = !xfer && restart_req;
            nxt     = xfer ? WR_REQ : state;
         end
         WR_REQ:   nxt = wrote_data_in ? WR_REL : WR_REQ;
         WR_REL: begin
            if (!wrote_data_in) begin
               restart = restart_req;
               if (!restart_req && count == LAST_PIX) begin
                  nxt  = IDLE;
                  done = 1'b1;
               end else if (!restart_req) begin
                  nxt       = WAIT_PIX;
                  nxt_count = count + 1'b1;
                  nxt_turn  = (turn == LAST_CORE) ? '0 : turn + 1'b1;
               end
            end
         end
         default:  nxt = IDLE;
      endcase
      if (restart) nxt = PTR_RST;
`ifdef FB_WRITE_SCHEDULER_ACK_TIMEOUT_EN
      tmo = (state == WR_REQ || state == WR_REL) && nxt == state && ack_cnt == ACK_LIM;
      if (tmo) nxt = IDLE;
`endif
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state               <= IDLE;
         turn                <= '0;
         count               <= '0;
         ptr_cnt             <= '0;
         pend                <= 1'b0;
         write_data_out      <= '0;
         core_ready_out      <= '0;
         write_strobe_out    <= 1'b0;
         reset_write_ptr_out <= 1'b0;
         frame_done_out      <= 1'b0;
         busy_out            <= 1'b0;
`ifdef FB_WRITE_SCHEDULER_ACK_TIMEOUT_EN
         ack_cnt             <= '0;
         ack_timeout_out     <= 1'b0;
`endif
      end else begin
         state               <= nxt;
         turn                <= nxt_turn;
         count               <= nxt_count;
         ptr_cnt             <= (state == PTR_RST && !restart) ? ptr_cnt + 1'b1 : '0;
         pend                <= !restart && nxt != IDLE && restart_req;
         write_data_out      <= xfer ? pix : write_data_out;
         core_ready_out      <= (nxt == WAIT_PIX) ? NUM_CORES'(1) << nxt_turn : '0;
         write_strobe_out    <= nxt == WR_REQ;
         reset_write_ptr_out <= nxt == PTR_RST;
         frame_done_out      <= done;
         busy_out            <= nxt != IDLE;
`ifdef FB_WRITE_SCHEDULER_ACK_TIMEOUT_EN
         ack_cnt             <= ((state == WR_REQ || state == WR_REL) && nxt == state) ? ack_cnt + 1'b1 : '0;
         ack_timeout_out     <= tmo | (ack_timeout_out & ~frame_start_in);
`endif
      end
   end
endmodule

// File: tb/tb_fb_write_scheduler.sv
// tb_fb_write_scheduler: table-driven frame plus ordering, handshake, restart, reset and watchdog sequences.
module tb_fb_write_scheduler;
   localparam int NC = 2, PPF = 8, PRC = 4, TO = 16;

   logic            clk = 0, rst_n = 1, frame_start_in = 0, wrote_data_in = 0;
   logic [NC-1:0]   core_valid_in = '0, core_ready_out;
   logic [4*NC-1:0] core_data_in = '0;
   logic [3:0]      write_data_out;
   logic            write_strobe_out, reset_write_ptr_out, frame_done_out, busy_out;
   logic [2:0]      pixel_index_out;
`ifdef FB_WRITE_SCHEDULER_ACK_TIMEOUT_EN
   logic            ack_timeout_out;
`endif

   int         total = 0, bad = 0, rp_cnt = 0, done_cnt = 0;
   bit         ack_auto = 0;
   logic [3:0] q[$];

   typedef struct {logic [3:0] d0, d1; logic [1:0] exp_ready; logic [3:0] exp_wd;} vec_t;
   vec_t tbl[PPF];

   always #5 clk = ~clk;

   fb_write_scheduler #(.NUM_CORES(NC), .PIXELS_PER_FRAME(PPF), .PTR_RESET_CYCLES(PRC), .ACK_TIMEOUT(TO)) dut (
      .clk(clk), .rst_n(rst_n), .frame_start_in(frame_start_in), .core_valid_in(core_valid_in),
      .core_data_in(core_data_in), .core_ready_out(core_ready_out), .write_data_out(write_data_out),
      .write_strobe_out(write_strobe_out), .reset_write_ptr_out(reset_write_ptr_out),
      .wrote_data_in(wrote_data_in), .frame_done_out(frame_done_out), .busy_out(busy_out),
`ifdef FB_WRITE_SCHEDULER_ACK_TIMEOUT_EN
      .ack_timeout_out(ack_timeout_out),
`endif
      .pixel_index_out(pixel_index_out));

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_ready();
      int n = 0;
      while (core_ready_out == '0 && n < 100) begin
         tick();
         n++;
      end
      if (core_ready_out == '0) begin
         total++;
         bad++;
         $display("FAIL ready_wait actual=no ready required=ready within 100 cycles");
      end
   endtask

   task automatic wait_idle();
      int n = 0;
      while (busy_out && n < 200) begin
         tick();
         n++;
      end
   endtask

   task automatic send(input logic [1:0] vmask, input logic [3:0] d0, input logic [3:0] d1,
                       input logic [1:0] exp_ready, input logic [3:0] exp_wd);
      wait_ready();
      chk("ready_turn", 32'(core_ready_out), 32'(exp_ready));
      core_data_in  = {d1, d0};
      core_valid_in = vmask;
      q.push_back(exp_wd);
      tick();
      core_valid_in = '0;
   endtask

   task automatic start_frame();
      frame_start_in = 1;
      tick();
      frame_start_in = 0;
   endtask

   // four-phase ack responder: follows the strobe two cycles late
   initial begin
      logic [1:0] sd;
      sd = '0;
      forever begin
         @(negedge clk);
         if (ack_auto) begin
            wrote_data_in = sd[1];
            sd = {sd[0], write_strobe_out};
         end else sd = '0;
      end
   end

   // scoreboard and pulse monitor
   initial begin
      logic prev_st, prev_wr;
      prev_st = 0;
      prev_wr = 0;
      forever begin
         tick();
         if (write_strobe_out && !prev_st) begin
            if (q.size() == 0) begin
               total++;
               bad++;
               $display("FAIL unexpected_write actual=%0h required=no write", write_data_out);
            end else chk("write_data", 32'(write_data_out), 32'(q.pop_front()));
         end
         if (reset_write_ptr_out) rp_cnt++;
         if (frame_done_out) begin
            done_cnt++;
            chk("done_idle", {30'd0, write_strobe_out, busy_out}, 0);
            chk("done_after_ack_fall", {30'd0, prev_wr, wrote_data_in}, 32'b10);
         end
         prev_st = write_strobe_out;
         prev_wr = wrote_data_in;
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog actual=still running required=finished");
      $fatal(1, "watchdog");
   end

   initial begin
      bit ok;
      tbl[0] = '{4'h1, 4'h9, 2'b01, 4'h1};
      tbl[1] = '{4'h2, 4'hA, 2'b10, 4'hA};
      tbl[2] = '{4'h3, 4'hB, 2'b01, 4'h3};
      tbl[3] = '{4'h4, 4'hC, 2'b10, 4'hC};
      tbl[4] = '{4'h5, 4'hD, 2'b01, 4'h5};
      tbl[5] = '{4'h6, 4'hE, 2'b10, 4'hE};
      tbl[6] = '{4'h7, 4'hF, 2'b01, 4'h7};
      tbl[7] = '{4'h0, 4'h8, 2'b10, 4'h8};

      #1 rst_n = 0;
      repeat (3) tick();
      chk("reset_outputs", {core_ready_out, write_data_out, write_strobe_out, reset_write_ptr_out,
                            frame_done_out, busy_out, pixel_index_out}, 0);
      rst_n = 1;
      tick();
      chk("idle_after_reset", {core_ready_out, busy_out}, 0);

      // basic frame: both cores always valid, DUT must pick the turn owner
      ack_auto = 1;
      rp_cnt = 0;
      done_cnt = 0;
      start_frame();
      for (int i = 0; i < PPF; i++) begin
         wait_ready();
         chk("pixel_index", 32'(pixel_index_out), i);
         send(2'b11, tbl[i].d0, tbl[i].d1, tbl[i].exp_ready, tbl[i].exp_wd);
      end
      wait_idle();
      tick();
      chk("ptr_reset_cycles", rp_cnt, PRC);
      chk("frame_done_count", done_cnt, 1);
      chk("busy_after_frame", 32'(busy_out), 0);
      chk("scoreboard_empty", q.size(), 0);

      // order enforcement: core1 waiting early must not jump ahead of core0
      done_cnt = 0;
      start_frame();
      core_data_in  = {4'hA, 4'h0};
      core_valid_in = 2'b10;
      wait_ready();
      ok = 1;
      repeat (20) begin
         if (core_ready_out != 2'b01) ok = 0;
         tick();
      end
      chk("order_ready_held", 32'(ok), 1);
      core_data_in  = {4'hA, 4'h5};
      core_valid_in = 2'b11;
      q.push_back(4'h5);
      q.push_back(4'hA);
      tick();
      core_valid_in = 2'b10;
      wait_ready();
      chk("order_second_ready", 32'(core_ready_out), 32'b10);
      tick();
      core_valid_in = '0;
      for (int i = 2; i < PPF; i++) send(tbl[i].exp_ready, tbl[i].d0, tbl[i].d1, tbl[i].exp_ready, tbl[i].exp_wd);
      wait_idle();
      tick();
      chk("order_frame_done", done_cnt, 1);

      // restart during WR_REQ of pixel 3
      done_cnt = 0;
      start_frame();
      for (int i = 0; i < 4; i++) send(tbl[i].exp_ready, tbl[i].d0, tbl[i].d1, tbl[i].exp_ready, tbl[i].exp_wd);
      chk("restart_in_wr_req", 32'(write_strobe_out), 1);
      start_frame();
      rp_cnt = 0;
      wait_ready();
      chk("restart_pixel3_written", q.size(), 0);
      chk("restart_ptr_cycles", rp_cnt, PRC);
      chk("restart_index", 32'(pixel_index_out), 0);
      chk("restart_ready", 32'(core_ready_out), 32'b01);
      chk("restart_no_done", done_cnt, 0);

      // handshake latency with a hand-driven ack
      ack_auto = 0;
      wrote_data_in = 0;
      start_frame();
      wait_ready();
      chk("hs_ready", 32'(core_ready_out), 32'b01);
      core_data_in  = {4'h0, 4'h3};
      core_valid_in = 2'b01;
      q.push_back(4'h3);
      tick();
      core_valid_in = '0;
      chk("hs_strobe_next_cycle", 32'(write_strobe_out), 1);
      chk("hs_data", 32'(write_data_out), 32'h3);
      repeat (3) tick();
      chk("hs_strobe_held", 32'(write_strobe_out), 1);
      wrote_data_in = 1;
      tick();
      chk("hs_strobe_drop", 32'(write_strobe_out), 0);
      chk("hs_ready_while_ack", 32'(core_ready_out), 0);
      tick();
      chk("hs_ready_while_ack2", 32'(core_ready_out), 0);
      chk("hs_data_stable", 32'(write_data_out), 32'h3);
      wrote_data_in = 0;
      tick();
      chk("hs_ready_after_release", 32'(core_ready_out), 32'b10);

      // async reset mid-handshake
      core_data_in  = {4'h7, 4'h0};
      core_valid_in = 2'b10;
      q.push_back(4'h7);
      tick();
      core_valid_in = '0;
      chk("ar_in_wr_req", 32'(write_strobe_out), 1);
      #2 rst_n = 0;
      #1 chk("ar_async_clear", {29'd0, write_strobe_out, core_ready_out}, 0);
      chk("ar_async_busy", 32'(busy_out), 0);
      tick();
      rst_n = 1;
      repeat (3) tick();
      chk("ar_idle_after", {core_ready_out, busy_out, reset_write_ptr_out, pixel_index_out}, 0);

`ifdef FB_WRITE_SCHEDULER_ACK_TIMEOUT_EN
      begin
         int n;
         start_frame();
         send(2'b01, 4'hC, 4'h0, 2'b01, 4'hC);
         n = 0;
         while (write_strobe_out && n < 40) begin
            n++;
            tick();
         end
         chk("to_strobe_cycles", n, TO);
         chk("to_flag", 32'(ack_timeout_out), 1);
         chk("to_idle", 32'(busy_out), 0);
         start_frame();
         chk("to_flag_cleared", 32'(ack_timeout_out), 0);
      end
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
